// File: rtl/vcdl_delay_cal.sv
// Calibration/sequencing controller for one VCDL delay chain: sweeps taps 0..31,
// finds the first 0->1 feedback edge and loads edge+offset. Optional drift tracking: VCDL_CAL_TRACK_EN.
module vcdl_delay_cal #(
  parameter int SETTLE_CYCLES = 16,
  parameter int SAMPLE_LOG2   = 4,
  parameter int EDGE_OFFSET   = 8
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [4:0] manual_delay_i,
  input  logic       manual_ld_i,
  input  logic       fb_q_i,
  output logic [4:0] delay_o,
  output logic       delay_ld_o,
  output logic       busy_o,
  output logic       lock_o,
  output logic       fail_o,
  output logic [4:0] edge_tap_o
);

  localparam int              CW          = SAMPLE_LOG2 + 1;
  localparam logic [CW-1:0]   HALF        = CW'((2 ** SAMPLE_LOG2) / 2);
  localparam logic [CW-1:0]   LAST_SAMPLE = CW'((2 ** SAMPLE_LOG2) - 1);
  localparam logic [7:0]      LAST_SETTLE = 8'(SETTLE_CYCLES - 1);
  localparam logic [5:0]      OFFSET      = 6'(EDGE_OFFSET);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL, S_APPLY, S_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    tap_q, tap_d;
  logic          prev_q, prev_d;
  logic [7:0]    settle_q, settle_d;
  logic [CW-1:0] sample_q, sample_d;
  logic [CW-1:0] ones_q, ones_d;
  logic [4:0]    delay_q, delay_d;
  logic          ld_q, ld_d;
  logic          busy_q, busy_d;
  logic          lock_q, lock_d;
  logic          fail_q, fail_d;
  logic [4:0]    edge_q, edge_d;
  logic          fb_meta, fb_s;

  // Majority with ties resolving to 0; for SAMPLE_LOG2=0 HALF is 0, so this is the lone sample.
  logic       samp_bit;
  logic [5:0] sum;
  logic [4:0] final_tap;
  assign samp_bit  = ones_q > HALF;
  assign sum       = {1'b0, edge_q} + OFFSET;
  assign final_tap = (sum > 6'd31) ? 5'd31 : sum[4:0];

`ifdef VCDL_CAL_TRACK_EN
  logic        trk_q, trk_d;
  logic [4:0]  final_q, final_d;
  logic [15:0] trk_cnt_q;
  logic        trk_wrap;
  assign trk_wrap = lock_q && !ld_q && (trk_cnt_q == 16'hFFFF);
`endif

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    tap_d    = tap_q;
    prev_d   = prev_q;
    settle_d = settle_q;
    sample_d = sample_q;
    ones_d   = ones_q;
    delay_d  = delay_q;
    ld_d     = 1'b0;
    busy_d   = busy_q;
    lock_d   = lock_q;
    fail_d   = fail_q;
    edge_d   = edge_q;
`ifdef VCDL_CAL_TRACK_EN
    trk_d    = trk_q;
    final_d  = final_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          tap_d   = 5'd0;
          busy_d  = 1'b1;
          lock_d  = 1'b0;
          fail_d  = 1'b0;
        end else if (manual_ld_i && !ld_q) begin
          delay_d = manual_delay_i;
          ld_d    = 1'b1;
          lock_d  = 1'b0;
        end
`ifdef VCDL_CAL_TRACK_EN
        else if (trk_wrap) begin
          state_d = S_LOAD;
          tap_d   = (final_q == 5'd0) ? 5'd0 : final_q - 5'd1;
          trk_d   = 1'b1;
        end
`endif
      end
      S_LOAD: begin
        delay_d  = tap_q;
        ld_d     = 1'b1;
        settle_d = 8'd0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        settle_d = settle_q + 8'd1;
        if (settle_q == LAST_SETTLE) begin
          ones_d   = '0;
          sample_d = '0;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        ones_d   = ones_q + CW'(fb_s);
        sample_d = sample_q + CW'(1);
        if (sample_q == LAST_SAMPLE) state_d = S_EVAL;
      end
      S_EVAL: begin
`ifdef VCDL_CAL_TRACK_EN
        if (trk_q) begin
          // A 1 one tap below final means the edge drifted down: follow it.
          if (samp_bit && final_q != 5'd0) final_d = final_q - 5'd1;
          delay_d = (samp_bit && final_q != 5'd0) ? final_q - 5'd1 : final_q;
          ld_d    = 1'b1;
          trk_d   = 1'b0;
          state_d = S_IDLE;
        end else
`endif
        if (tap_q != 5'd0 && !prev_q && samp_bit) begin
          edge_d  = tap_q;
          state_d = S_APPLY;
        end else begin
          prev_d = samp_bit;
          if (tap_q == 5'd31) begin
            state_d = S_FAIL;
          end else begin
            tap_d   = tap_q + 5'd1;
            state_d = S_LOAD;
          end
        end
      end
      S_APPLY: begin
        delay_d = final_tap;
        ld_d    = 1'b1;
        lock_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef VCDL_CAL_TRACK_EN
        final_d = final_tap;
`endif
      end
      S_FAIL: begin
        delay_d = 5'd0;
        ld_d    = 1'b1;
        fail_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef VCDL_CAL_TRACK_EN
    // Tracking runs with busy low, so user commands preempt it.
    if (trk_q && state_q != S_IDLE && (start_i || manual_ld_i)) begin
      trk_d   = 1'b0;
      lock_d  = 1'b0;
      ld_d    = 1'b0;
      delay_d = delay_q;
      state_d = S_IDLE;
      if (start_i) begin
        state_d = S_LOAD;
        tap_d   = 5'd0;
        busy_d  = 1'b1;
        fail_d  = 1'b0;
      end else if (!ld_q) begin
        delay_d = manual_delay_i;
        ld_d    = 1'b1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tap_q    <= 5'd0;
      prev_q   <= 1'b0;
      settle_q <= 8'd0;
      sample_q <= '0;
      ones_q   <= '0;
      delay_q  <= 5'd0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      lock_q   <= 1'b0;
      fail_q   <= 1'b0;
      edge_q   <= 5'd0;
      fb_meta  <= 1'b0;
      fb_s     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      sample_q <= sample_d;
      ones_q   <= ones_d;
      delay_q  <= delay_d;
      ld_q     <= ld_d;
      busy_q   <= busy_d;
      lock_q   <= lock_d;
      fail_q   <= fail_d;
      edge_q   <= edge_d;
      fb_meta  <= fb_q_i;
      fb_s     <= fb_meta;
    end
  end

`ifdef VCDL_CAL_TRACK_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      trk_q     <= 1'b0;
      final_q   <= 5'd0;
      trk_cnt_q <= 16'd0;
    end else begin
      trk_q     <= trk_d;
      final_q   <= final_d;
      trk_cnt_q <= (lock_q && state_q == S_IDLE && !trk_q) ? trk_cnt_q + 16'd1 : 16'd0;
    end
  end
`endif

  assign delay_o    = delay_q;
  assign delay_ld_o = ld_q;
  assign busy_o     = busy_q;
  assign lock_o     = lock_q;
  assign fail_o     = fail_q;
  assign edge_tap_o = edge_q;

endmodule

// File: tb/tb_vcdl_delay_cal.sv
// Directed bench for vcdl_delay_cal: feedback model driven from the loaded tap,
// hand-computed expectations for edge, saturation, fail, tie, manual load and reset cases.
module tb_vcdl_delay_cal;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic [4:0] manual_delay_i = 5'd0;
  logic       manual_ld_i = 1'b0;
  logic       fb_q_i = 1'b0;
  logic [4:0] delay_o;
  logic       delay_ld_o;
  logic       busy_o;
  logic       lock_o;
  logic       fail_o;
  logic [4:0] edge_tap_o;

  vcdl_delay_cal #(.SETTLE_CYCLES(16), .SAMPLE_LOG2(4), .EDGE_OFFSET(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .manual_delay_i(manual_delay_i), .manual_ld_i(manual_ld_i), .fb_q_i(fb_q_i),
    .delay_o(delay_o), .delay_ld_o(delay_ld_o), .busy_o(busy_o), .lock_o(lock_o),
    .fail_o(fail_o), .edge_tap_o(edge_tap_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int spacing_err = 0;
  logic prev_ld = 1'b0;
  int fb_mode = 0;   // 0: fb = (tap >= fb_thr); 1: tie pattern at 12, majority from 13
  int fb_thr = 12;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Feedback model: depends only on the tap the DUT has loaded.
  always @(negedge clk_i) begin
    cyc++;
    if (fb_mode == 0) fb_q_i = (int'(delay_o) >= fb_thr);
    else if (delay_o < 5'd12) fb_q_i = 1'b0;
    else if (delay_o == 5'd12) fb_q_i = cyc[0];
    else fb_q_i = (cyc % 3) != 0;
  end

  always @(negedge clk_i) begin
    if (delay_ld_o) strobe_cnt++;
    if (delay_ld_o && prev_ld) spacing_err++;
    prev_ld = delay_ld_o;
  end

  task automatic run_sweep(input bit poke_manual, output int strobes);
    int s0;
    bit done;
    s0 = strobe_cnt;
    @(negedge clk_i) start_i = 1'b1;
    @(negedge clk_i) start_i = 1'b0;
    check("busy_after_start", busy_o, 1);
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk_i);
      if (poke_manual && i == 40) begin manual_delay_i = 5'd7; manual_ld_i = 1'b1; end
      if (poke_manual && i == 41) manual_ld_i = 1'b0;
      if (!busy_o) done = 1'b1;
    end
    check("sweep_done", done, 1);
    @(negedge clk_i);
    strobes = strobe_cnt - s0;
  endtask

  task automatic manual_load(input logic [4:0] val, output int strobes);
    int s0;
    s0 = strobe_cnt;
    @(negedge clk_i) begin manual_delay_i = val; manual_ld_i = 1'b1; end
    @(negedge clk_i) manual_ld_i = 1'b0;
    @(negedge clk_i);
    strobes = strobe_cnt - s0;
  endtask

  initial begin
    int n;
    bit found;
    #12;
    check("rst_delay", delay_o, 0);
    check("rst_ld", delay_ld_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_lock", lock_o, 0);
    check("rst_fail", fail_o, 0);
    check("rst_edge", edge_tap_o, 0);
    @(negedge clk_i) rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Edge at tap 12 -> final 20
    fb_mode = 0; fb_thr = 12;
    run_sweep(1'b0, n);
    check("e12_edge", edge_tap_o, 12);
    check("e12_delay", delay_o, 20);
    check("e12_lock", lock_o, 1);
    check("e12_fail", fail_o, 0);
    check("e12_strobes", n, 14);

    manual_load(5'd7, n);
    check("man_delay", delay_o, 7);
    check("man_strobes", n, 1);
    check("man_lock_clr", lock_o, 0);

    // Edge at 28 -> saturates to 31
    fb_thr = 28;
    run_sweep(1'b0, n);
    check("e28_edge", edge_tap_o, 28);
    check("e28_delay", delay_o, 31);
    check("e28_lock", lock_o, 1);
    check("e28_strobes", n, 30);

    // Stuck at 0
    fb_thr = 32;
    run_sweep(1'b0, n);
    check("s0_fail", fail_o, 1);
    check("s0_lock", lock_o, 0);
    check("s0_delay", delay_o, 0);
    check("s0_strobes", n, 33);

    manual_load(5'd7, n);
    check("man2_delay", delay_o, 7);
    check("man2_fail_kept", fail_o, 1);

    // Stuck at 1
    fb_thr = 0;
    run_sweep(1'b0, n);
    check("s1_fail", fail_o, 1);
    check("s1_lock", lock_o, 0);
    check("s1_delay", delay_o, 0);
    check("s1_strobes", n, 33);

    // 8-of-16 tie at tap 12 reads as 0; edge lands on 13
    fb_mode = 1;
    run_sweep(1'b0, n);
    check("tie_edge", edge_tap_o, 13);
    check("tie_delay", delay_o, 21);
    check("tie_lock", lock_o, 1);
    check("tie_fail", fail_o, 0);

    // start and manual together: sweep wins, no manual strobe
    fb_mode = 0; fb_thr = 12;
    @(negedge clk_i) begin start_i = 1'b1; manual_ld_i = 1'b1; manual_delay_i = 5'd9; end
    @(negedge clk_i) begin start_i = 1'b0; manual_ld_i = 1'b0; end
    check("sim_no_strobe", delay_ld_o, 0);
    check("sim_busy", busy_o, 1);
    check("sim_lock_clr", lock_o, 0);
    @(negedge clk_i);
    check("sim_tap0_strobe", delay_ld_o, 1);
    check("sim_tap0_delay", delay_o, 0);

    // Async reset while settling at tap 5
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_i);
      if (delay_ld_o && delay_o == 5'd5) found = 1'b1;
    end
    check("tap5_reached", found, 1);
    repeat (3) @(negedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_delay", delay_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_lock", lock_o, 0);
    check("arst_fail", fail_o, 0);
    check("arst_edge", edge_tap_o, 0);
    repeat (3) @(negedge clk_i);
    check("arst_no_strobe", delay_ld_o, 0);
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // Fresh sweep; a manual pulse mid-sweep must be ignored
    run_sweep(1'b1, n);
    check("fresh_edge", edge_tap_o, 12);
    check("fresh_delay", delay_o, 20);
    check("fresh_lock", lock_o, 1);
    check("fresh_strobes", n, 14);
    check("strobe_spacing", spacing_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vcdl_delay_cal.md
Name: vcdl_delay_cal

Overview:
Calibration and sequencing controller for one VCDL delay chain. It drives the 5-bit tap load interface (delay value, load strobe) and sweeps taps 0..31. At each tap it samples the synchronized feedback bit. It finds the first 0->1 feedback transition and applies the edge tap plus a fixed offset. It sits between the control register block and the VCDL wrapper, on the delay-load clock domain.

Parameters:
SETTLE_CYCLES, 16, clk_i cycles waited after each tap load before sampling (1..255)
SAMPLE_LOG2, 4, log2 of feedback samples taken per tap (0..7)
EDGE_OFFSET, 8, taps added to the detected edge tap before final load (0..31)

Ports:
clk_i  in  1  controller clock; same clock drives the VCDL delay_clk_i
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  single-cycle pulse; begins calibration sweep
manual_delay_i  in  5  tap value for manual load
manual_ld_i  in  1  single-cycle pulse; load manual_delay_i when not busy
fb_q_i  in  1  VCDL feedback bit, asynchronous to clk_i
delay_o  out  5  tap value to VCDL delay_i
delay_ld_o  out  1  one-cycle load strobe to VCDL delay_ld_i
busy_o  out  1  sweep in progress
lock_o  out  1  calibration succeeded; cleared on start or manual load
fail_o  out  1  no edge found in last sweep
edge_tap_o  out  5  detected edge tap (valid when lock_o)

Behaviour:
- Reset values: delay_o=0, delay_ld_o=0, busy_o=0, lock_o=0, fail_o=0, edge_tap_o=0. FSM=IDLE. Sync flops=0.
- fb_q_i passes through a 2-flop synchronizer. Only the synchronized bit fb_s is used.
- States: IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY, FAIL.
- IDLE: start_i -> LOAD with tap=0. busy_o=1 from the next cycle; lock_o and fail_o clear.
- IDLE: manual_ld_i (no start_i) -> delay_o=manual_delay_i and delay_ld_o=1 for one cycle. lock_o clears; fail_o unchanged.
- IDLE: start_i and manual_ld_i in the same cycle -> start wins; the manual load is dropped.
- LOAD: delay_o=tap, delay_ld_o=1 for exactly one cycle -> SETTLE. The settle counter is cleared.
- SETTLE: count SETTLE_CYCLES cycles -> SAMPLE. The ones counter and the sample counter are cleared.
- SAMPLE: one fb_s sample per cycle for 2^SAMPLE_LOG2 cycles. The ones counter is SAMPLE_LOG2+1 bits wide -> EVAL.
- EVAL: bit = (ones > 2^(SAMPLE_LOG2-1)); ties resolve to 0. For SAMPLE_LOG2=0, bit = the single sample.
- EVAL, tap=0: store bit as prev. Tap 0 is never an edge.
- EVAL, tap>0 with prev=0 and bit=1: edge_tap_o=tap -> APPLY.
- EVAL otherwise: prev=bit. If tap=31 -> FAIL, else tap+1 -> LOAD. No wrap past 31.
- APPLY: final = min(edge_tap+EDGE_OFFSET, 31), computed in 6 bits and saturating. delay_o=final, delay_ld_o=1 for one cycle, lock_o=1, busy_o=0 -> IDLE.
- FAIL: delay_o=0, delay_ld_o=1 for one cycle, fail_o=1, busy_o=0 -> IDLE.
- start_i and manual_ld_i are ignored while busy_o=1.
- delay_o holds its last loaded value between strobes.
- At most one delay_ld_o pulse per 2 cycles.
- Reset asserted mid-sweep: all outputs return to reset values immediately. No load strobe is issued.
- Sweep latency per tap: 1 + SETTLE_CYCLES + 2^SAMPLE_LOG2 + 1 cycles.

Optional Feature:
Macro VCDL_CAL_TRACK_EN.
- Defined: while lock_o=1 and the FSM is in IDLE, a 16-bit free-running counter triggers a re-check on wrap.
  - Re-check sequence: load (final-1), settle, sample. If the majority bit is 1, the edge moved down; decrement final (floor 0) and reload.
  - Otherwise no change.
  - busy_o stays 0 during tracking. A manual_ld_i during tracking aborts tracking and clears lock_o.
- Undefined: no tracking logic; lock_o holds until start_i, manual_ld_i or reset.

Test Plan:
- Feedback model returns 1 for tap>=12 (else 0), SETTLE_CYCLES=16, SAMPLE_LOG2=4, EDGE_OFFSET=8; pulse start_i -> edge_tap_o=12, final delay_o=20, lock_o=1, fail_o=0; 13 load strobes plus one final strobe.
- Edge at tap 28, EDGE_OFFSET=8 -> delay_o saturates to 31, lock_o=1.
- Feedback stuck at 0 (also stuck at 1) -> all 32 taps swept, fail_o=1, lock_o=0, delay_o=0 with a final strobe.
- Feedback 50% random at tap 12, exactly 8 of 16 ones -> bit=0 (tie), edge reported at the first tap with >=9 ones.
- manual_ld_i with manual_delay_i=7 while idle -> one strobe, delay_o=7; same pulse while busy -> ignored; simultaneous with start_i -> sweep starts, no manual strobe.
- rst_n_i asserted at tap 5 in SETTLE -> all outputs 0 asynchronously; after release, start_i runs a full fresh sweep from tap 0.
